// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use bubbles,
// multi-cycle MUL/DIV hold and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned LU_CYCLES  = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              reg_writeM,
  input  logic              reg_writeW,
  input  logic [1:0]        result_srcE,
  input  logic              pc_srcE,
  input  logic              md_startE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // md_cnt holds at most MD_LATENCY-2, lu_cnt at most LU_CYCLES-1.
  localparam int unsigned MdW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
  localparam int unsigned LuW = (LU_CYCLES > 2) ? $clog2(LU_CYCLES) : 1;

  typedef enum logic {MdIdle, MdBusy} md_state_e;

  md_state_e        md_state_q;
  logic [MdW-1:0]   md_cnt_q;
  logic [LuW-1:0]   lu_cnt_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic lw_haz;
  logic md_hold;
  logic lu_hold;
  logic unused_res_hi;

  assign unused_res_hi = result_srcE[1];
  assign md_busy       = (md_state_q == MdBusy);
  assign stall_cycles  = stall_cycles_q;

  always_comb begin
    lw_haz  = result_srcE[0] && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    md_hold = ((md_state_q == MdIdle) && md_startE && (MD_LATENCY > 1)) ||
              ((md_state_q == MdBusy) && (md_cnt_q != '0));
    lu_hold = (lu_cnt_q != '0) || (lw_haz && !md_hold && !pc_srcE);

    forwardAE = 2'b00;
    forwardBE = 2'b00;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;

    if (!rst) begin
      if ((rs1E == rdM) && reg_writeM && (rs1E != '0)) begin
        forwardAE = 2'b10;
      end else if ((rs1E == rdW) && reg_writeW && (rs1E != '0)) begin
        forwardAE = 2'b01;
      end
      if ((rs2E == rdM) && reg_writeM && (rs2E != '0)) begin
        forwardBE = 2'b10;
      end else if ((rs2E == rdW) && reg_writeW && (rs2E != '0)) begin
        forwardBE = 2'b01;
      end

      // The MUL/DIV op must stay in E, so M gets the bubble instead of E.
      if (md_hold) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (pc_srcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lu_hold) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_state_q     <= MdIdle;
      md_cnt_q       <= '0;
      lu_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      unique case (md_state_q)
        MdIdle: begin
          if (md_startE && (MD_LATENCY > 1)) begin
            md_state_q <= MdBusy;
            md_cnt_q   <= MdW'(MD_LATENCY - 2);
          end
        end
        MdBusy: begin
          if (md_cnt_q != '0) begin
            md_cnt_q <= md_cnt_q - 1'b1;
          end else begin
            md_state_q <= MdIdle;
          end
        end
        default: md_state_q <= MdIdle;
      endcase

      // A taken branch squashes any pending load-use bubbles.
      if (pc_srcE && !md_hold) begin
        lu_cnt_q <= '0;
      end else if (lu_cnt_q != '0) begin
        lu_cnt_q <= lu_cnt_q - 1'b1;
      end else if (lw_haz && !md_hold) begin
        lu_cnt_q <= LuW'(LU_CYCLES - 1);
      end

      if (stallF && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: table of single-cycle vectors plus
// hand-written multi-cycle sequences (MUL/DIV hold, load-use, reset, saturation).
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       reg_writeM, reg_writeW;
  logic [1:0] result_srcE;
  logic       pc_srcE, md_startE;

  logic        stallF, stallD, stallE, flushD, flushE, flushM, md_busy;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] stall_cycles;

  logic        s_stallF, s_stallD, s_stallE, s_flushD, s_flushE, s_flushM, s_md_busy;
  logic [1:0]  s_fwdA, s_fwdB;
  logic [3:0]  s_stall_cycles;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(4), .LU_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .result_srcE(result_srcE), .pc_srcE(pc_srcE), .md_startE(md_startE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .forwardAE(forwardAE), .forwardBE(forwardBE), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(4), .LU_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .result_srcE(result_srcE), .pc_srcE(pc_srcE), .md_startE(md_startE),
    .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .flushD(s_flushD),
    .flushE(s_flushE), .flushM(s_flushM), .forwardAE(s_fwdA), .forwardBE(s_fwdB),
    .md_busy(s_md_busy), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rwM, rwW;
    logic [1:0] res;
    logic       pc;
    logic [1:0] exp_fa, exp_fb;
    logic       exp_stallF, exp_stallD, exp_flushD, exp_flushE;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    reg_writeM = 0; reg_writeW = 0; result_srcE = 0; pc_srcE = 0; md_startE = 0;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_stalls(input string name, input logic f, input logic e, input logic m);
    check({name, ".stallF"}, 32'(stallF), 32'(f));
    check({name, ".stallE"}, 32'(stallE), 32'(e));
    check({name, ".flushM"}, 32'(flushM), 32'(m));
  endtask

  initial begin
    //          rs1D rs2D rs1E rs2E rdE rdM rdW rwM rwW res pc  fa     fb     sF sD fD fE
    tbl[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 3, 0, 0, 4, 3, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 6, 0, 6, 6, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 9, 9, 0, 9, 2, 1, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 8, 0, 0, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[6]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1};
    tbl[10] = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1};

    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    // Outputs while reset is held
    rs1E = 5; rdM = 5; reg_writeM = 1; md_startE = 1; pc_srcE = 1;
    #1;
    check("rst.forwardAE", 32'(forwardAE), 0);
    check("rst.flushD", 32'(flushD), 0);
    chk_stalls("rst", 0, 0, 0);
    check("rst.stall_cycles", stall_cycles, 0);
    idle_inputs();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_reset();
      rs1D = tbl[i].rs1D; rs2D = tbl[i].rs2D; rs1E = tbl[i].rs1E; rs2E = tbl[i].rs2E;
      rdE = tbl[i].rdE; rdM = tbl[i].rdM; rdW = tbl[i].rdW;
      reg_writeM = tbl[i].rwM; reg_writeW = tbl[i].rwW;
      result_srcE = tbl[i].res; pc_srcE = tbl[i].pc;
      #1;
      check($sformatf("vec%0d.forwardAE", i), 32'(forwardAE), 32'(tbl[i].exp_fa));
      check($sformatf("vec%0d.forwardBE", i), 32'(forwardBE), 32'(tbl[i].exp_fb));
      check($sformatf("vec%0d.stallF", i), 32'(stallF), 32'(tbl[i].exp_stallF));
      check($sformatf("vec%0d.stallD", i), 32'(stallD), 32'(tbl[i].exp_stallD));
      check($sformatf("vec%0d.flushD", i), 32'(flushD), 32'(tbl[i].exp_flushD));
      check($sformatf("vec%0d.flushE", i), 32'(flushE), 32'(tbl[i].exp_flushE));
    end

    // MUL/DIV hold, MD_LATENCY=4; pc_srcE in cycle 2 must be masked
    do_reset();
    md_startE = 1; #1;
    chk_stalls("md.c1", 1, 1, 1);
    check("md.c1.busy", 32'(md_busy), 0);
    tick(); pc_srcE = 1; #1;
    chk_stalls("md.c2", 1, 1, 1);
    check("md.c2.busy", 32'(md_busy), 1);
    check("md.c2.flushD", 32'(flushD), 0);
    tick(); pc_srcE = 0; #1;
    chk_stalls("md.c3", 1, 1, 1);
    check("md.c3.busy", 32'(md_busy), 1);
    tick(); #1;
    chk_stalls("md.c4", 0, 0, 0);
    check("md.c4.busy", 32'(md_busy), 1);
    check("md.c4.stall_cycles", stall_cycles, 3);
    tick(); md_startE = 0; #1;
    check("md.c5.busy", 32'(md_busy), 0);
    chk_stalls("md.c5", 0, 0, 0);

    // Load-use, LU_CYCLES=2: load then bubble gives exactly two stall cycles
    do_reset();
    result_srcE = 1; rdE = 7; rs2D = 7; #1;
    check("lu.c1.stallF", 32'(stallF), 1);
    check("lu.c1.stallE", 32'(stallE), 0);
    check("lu.c1.flushE", 32'(flushE), 1);
    tick(); result_srcE = 0; #1;
    check("lu.c2.stallD", 32'(stallD), 1);
    check("lu.c2.flushE", 32'(flushE), 1);
    tick(); #1;
    check("lu.c3.stallF", 32'(stallF), 0);
    check("lu.c3.flushE", 32'(flushE), 0);
    check("lu.stall_cycles", stall_cycles, 2);

    // Taken branch while a load-use bubble is pending
    do_reset();
    result_srcE = 1; rdE = 7; rs1D = 7; #1;
    check("br.c1.stallF", 32'(stallF), 1);
    tick(); result_srcE = 0; pc_srcE = 1; #1;
    check("br.c2.flushD", 32'(flushD), 1);
    check("br.c2.flushE", 32'(flushE), 1);
    check("br.c2.stallF", 32'(stallF), 0);
    tick(); pc_srcE = 0; #1;
    check("br.c3.stallF", 32'(stallF), 0);
    check("br.c3.flushE", 32'(flushE), 0);

    // Reset in the second cycle of a MUL/DIV hold
    do_reset();
    md_startE = 1; #1;
    chk_stalls("mr.c1", 1, 1, 1);
    tick(); rst = 1; #1;
    chk_stalls("mr.c2", 0, 0, 0);
    tick(); rst = 0; md_startE = 0; #1;
    chk_stalls("mr.c3", 0, 0, 0);
    check("mr.c3.busy", 32'(md_busy), 0);
    check("mr.c3.stall_cycles", stall_cycles, 0);
    tick(); md_startE = 1; #1;
    chk_stalls("mr.c4", 1, 1, 1);
    tick(); #1;
    chk_stalls("mr.c5", 1, 1, 1);
    tick(); #1;
    chk_stalls("mr.c6", 1, 1, 1);
    tick(); #1;
    chk_stalls("mr.c7", 0, 0, 0);
    tick(); md_startE = 0; #1;
    check("mr.stall_cycles", stall_cycles, 3);

    // 20 back-to-back load-use stall cycles: 4-bit counter saturates at 15
    do_reset();
    result_srcE = 1; rdE = 3; rs1D = 3;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stallF !== 1'b1) begin
        nchecks++;
        nerrors++;
        $display("FAIL sat.stallF cycle %0d: got %b, expected 1", c, stallF);
      end
      tick();
    end
    result_srcE = 0; #1;
    check("sat.stallF_after", 32'(stallF), 0);
    check("sat.stall_cycles_w4", 32'(s_stall_cycles), 15);
    check("sat.stall_cycles_w32", stall_cycles, 20);
    tick(); #1;
    check("sat.stall_cycles_w4_hold", 32'(s_stall_cycles), 15);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
